// File: rtl/id_ex_stage_reg_pkg.sv
// Shared decode/execute definitions: ALU command encodings, instruction modes,
// status flag positions and the packed control-field layout of the ID/EX slot.
package id_ex_stage_reg_pkg;

  typedef enum logic [3:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    MODE_DP     = 2'b00,
    MODE_MEM    = 2'b01,
    MODE_BRANCH = 2'b10
  } mode_e;

  localparam int unsigned NZCV_N = 3;
  localparam int unsigned NZCV_Z = 2;
  localparam int unsigned NZCV_C = 1;
  localparam int unsigned NZCV_V = 0;

  // All-zero value of this struct is a NOP with valid cleared.
  typedef struct packed {
    exe_cmd_e exe_cmd;
    logic     mem_read;
    logic     mem_write;
    logic     wb_en;
    logic     b;
    logic     s;
    logic     imm;
    logic     valid;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_reg_field.sv
// Generic pipeline field register: async reset, hold when en is low,
// synchronous clear when enabled.
module pipe_field_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      if (clr) q <= '0;
      else     q <= d;
    end
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded control and operands, holds on
// freeze, inserts bubbles on flush/bubble_in, and counts stalls and bubbles.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              bubble_in,
  input  logic [3:0]        exe_cmd_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              wb_en_in,
  input  logic              b_in,
  input  logic              s_in,
  input  logic              imm_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val_rn_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm24_in,
  input  logic [3:0]        dest_in,
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  input  logic [3:0]        status_in,
  output logic [3:0]        exe_cmd_out,
  output logic              mem_read_out,
  output logic              mem_write_out,
  output logic              wb_en_out,
  output logic              b_out,
  output logic              s_out,
  output logic              imm_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] val_rn_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm24_out,
  output logic [3:0]        dest_out,
  output logic [3:0]        src1_out,
  output logic [3:0]        src2_out,
  output logic [3:0]        status_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int unsigned CTRL_W = $bits(ctrl_t);
  localparam int unsigned DGRP_W = 3 * DATA_W + 12 + 24 + 4 * 4;

  ctrl_t              w_ctrl_d;
  ctrl_t              w_ctrl_q;
  logic [CTRL_W-1:0]  w_ctrl_q_raw;
  logic [DGRP_W-1:0]  w_data_d;
  logic [DGRP_W-1:0]  w_data_q;
  logic               w_en;
  logic               w_ctrl_clr;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_bubble_cnt;

  assign w_en       = ~freeze;
  assign w_ctrl_clr = flush | bubble_in;

  always_comb begin
    w_ctrl_d           = '0;
    w_ctrl_d.exe_cmd   = exe_cmd_e'(exe_cmd_in);
    w_ctrl_d.mem_read  = mem_read_in;
    w_ctrl_d.mem_write = mem_write_in;
    w_ctrl_d.wb_en     = wb_en_in;
    w_ctrl_d.b         = b_in;
    w_ctrl_d.s         = s_in;
    w_ctrl_d.imm       = imm_in;
    w_ctrl_d.valid     = 1'b1;
  end

  assign w_data_d = {pc_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm24_in,
                     dest_in, src1_in, src2_in, status_in};

  // Data keeps loading on bubble_in so forwarding index compares stay defined.
  pipe_field_reg #(.W(CTRL_W)) u_ctrl_reg (
    .clk (clk),
    .rst (rst),
    .en  (w_en),
    .clr (w_ctrl_clr),
    .d   (w_ctrl_d),
    .q   (w_ctrl_q_raw)
  );

  pipe_field_reg #(.W(DGRP_W)) u_data_reg (
    .clk (clk),
    .rst (rst),
    .en  (w_en),
    .clr (flush),
    .d   (w_data_d),
    .q   (w_data_q)
  );

  assign w_ctrl_q      = ctrl_t'(w_ctrl_q_raw);
  assign exe_cmd_out   = w_ctrl_q.exe_cmd;
  assign mem_read_out  = w_ctrl_q.mem_read;
  assign mem_write_out = w_ctrl_q.mem_write;
  assign wb_en_out     = w_ctrl_q.wb_en;
  assign b_out         = w_ctrl_q.b;
  assign s_out         = w_ctrl_q.s;
  assign imm_out       = w_ctrl_q.imm;
  assign valid_out     = w_ctrl_q.valid;

  assign {pc_out, val_rn_out, val_rm_out, shift_operand_out, signed_imm24_out,
          dest_out, src1_out, src2_out, status_out} = w_data_q;

  // A flush during freeze is not counted; the branch re-asserts it afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (freeze) begin
      if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
    end else if (flush || bubble_in) begin
      if (r_bubble_cnt != '1) r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios then random
// traffic compared against a rule-level model of the slot.
module tb_id_ex_stage_reg;
  import id_ex_stage_reg_pkg::*;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [3:0]        exe_cmd;
    logic              mr, mw, wb, b, s, imm;
    logic [DATA_W-1:0] pc, rn, rm;
    logic [11:0]       sh;
    logic [23:0]       i24;
    logic [3:0]        dest, s1, s2, st;
  } fields_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    freeze = 1'b0, flush = 1'b0, bubble_in = 1'b0;
  fields_t in_f = '0;

  fields_t     exp_f = '0;
  logic        exp_valid = 1'b0;
  int unsigned exp_stall = 0, exp_bubble = 0;
  int unsigned n_checks = 0, n_errors = 0;

  logic [3:0]        exe_cmd_out;
  logic              mem_read_out, mem_write_out, wb_en_out, b_out, s_out, imm_out;
  logic [DATA_W-1:0] pc_out, val_rn_out, val_rm_out;
  logic [11:0]       shift_operand_out;
  logic [23:0]       signed_imm24_out;
  logic [3:0]        dest_out, src1_out, src2_out, status_out;
  logic              valid_out;
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

  id_ex_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .bubble_in(bubble_in),
    .exe_cmd_in(in_f.exe_cmd), .mem_read_in(in_f.mr), .mem_write_in(in_f.mw),
    .wb_en_in(in_f.wb), .b_in(in_f.b), .s_in(in_f.s), .imm_in(in_f.imm),
    .pc_in(in_f.pc), .val_rn_in(in_f.rn), .val_rm_in(in_f.rm),
    .shift_operand_in(in_f.sh), .signed_imm24_in(in_f.i24),
    .dest_in(in_f.dest), .src1_in(in_f.s1), .src2_in(in_f.s2), .status_in(in_f.st),
    .exe_cmd_out(exe_cmd_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .wb_en_out(wb_en_out), .b_out(b_out), .s_out(s_out), .imm_out(imm_out),
    .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .shift_operand_out(shift_operand_out), .signed_imm24_out(signed_imm24_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out), .status_out(status_out),
    .valid_out(valid_out), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("exe_cmd",   32'(exe_cmd_out),       32'(exp_f.exe_cmd));
    check("mem_read",  32'(mem_read_out),      32'(exp_f.mr));
    check("mem_write", 32'(mem_write_out),     32'(exp_f.mw));
    check("wb_en",     32'(wb_en_out),         32'(exp_f.wb));
    check("b",         32'(b_out),             32'(exp_f.b));
    check("s",         32'(s_out),             32'(exp_f.s));
    check("imm",       32'(imm_out),           32'(exp_f.imm));
    check("pc",        32'(pc_out),            32'(exp_f.pc));
    check("val_rn",    32'(val_rn_out),        32'(exp_f.rn));
    check("val_rm",    32'(val_rm_out),        32'(exp_f.rm));
    check("shift_op",  32'(shift_operand_out), 32'(exp_f.sh));
    check("imm24",     32'(signed_imm24_out),  32'(exp_f.i24));
    check("dest",      32'(dest_out),          32'(exp_f.dest));
    check("src1",      32'(src1_out),          32'(exp_f.s1));
    check("src2",      32'(src2_out),          32'(exp_f.s2));
    check("status",    32'(status_out),        32'(exp_f.st));
    check("valid",     32'(valid_out),         32'(exp_valid));
    check("stall_cnt", 32'(stall_cnt),         exp_stall);
    check("bubble_cnt",32'(bubble_cnt),        exp_bubble);
  endtask

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  // Rule-level view of one clock edge, evaluated in priority order.
  task automatic model_edge();
    if (freeze) begin
      exp_stall = sat_inc(exp_stall);
    end else if (flush) begin
      exp_f      = '0;
      exp_valid  = 1'b0;
      exp_bubble = sat_inc(exp_bubble);
    end else if (bubble_in) begin
      exp_f         = in_f;
      exp_f.exe_cmd = '0;
      {exp_f.mr, exp_f.mw, exp_f.wb, exp_f.b, exp_f.s, exp_f.imm} = '0;
      exp_valid     = 1'b0;
      exp_bubble    = sat_inc(exp_bubble);
    end else begin
      exp_f     = in_f;
      exp_valid = 1'b1;
    end
  endtask

  task automatic model_reset();
    exp_f = '0; exp_valid = 1'b0; exp_stall = 0; exp_bubble = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  function automatic fields_t rand_fields();
    fields_t f;
    f.exe_cmd = 4'($urandom_range(0, 9));
    {f.mr, f.mw, f.wb, f.b, f.s, f.imm} = 6'($urandom);
    f.pc   = $urandom; f.rn = $urandom; f.rm = $urandom;
    f.sh   = 12'($urandom); f.i24 = 24'($urandom);
    f.dest = 4'($urandom); f.s1 = 4'($urandom); f.s2 = 4'($urandom); f.st = 4'($urandom);
    return f;
  endfunction

  initial begin
    model_reset();
    #12;
    check_all();
    rst = 1'b0;

    // Load an ADD
    in_f = '0; in_f.exe_cmd = EXE_ADD; in_f.wb = 1'b1;
    in_f.pc = 32'h10; in_f.rn = 32'd5; in_f.rm = 32'd7;
    tick();
    check("load_valid", 32'(valid_out), 32'd1);
    check("load_pc", pc_out, 32'h10);

    // Freeze for 3 cycles with changing inputs
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin in_f = rand_fields(); tick(); end
    check("freeze_stall3", 32'(stall_cnt), 32'd3);
    check("freeze_pc", pc_out, 32'h10);
    freeze = 1'b0;

    // Load a STR, then freeze+flush, then flush alone
    in_f = rand_fields(); in_f.mw = 1'b1; in_f.mr = 1'b0; tick();
    freeze = 1'b1; flush = 1'b1; in_f = rand_fields(); tick();
    check("ff_mem_write", 32'(mem_write_out), 32'd1);
    check("ff_bubble0", 32'(bubble_cnt), 32'd0);
    freeze = 1'b0; tick();
    check("flush_valid", 32'(valid_out), 32'd0);
    check("flush_pc", pc_out, 32'd0);
    check("flush_bubble1", 32'(bubble_cnt), 32'd1);

    // Bubble keeps indices
    flush = 1'b0; bubble_in = 1'b1;
    in_f = rand_fields(); in_f.dest = 4'd3; in_f.wb = 1'b1; tick();
    check("bub_wb", 32'(wb_en_out), 32'd0);
    check("bub_dest", 32'(dest_out), 32'd3);

    // Flush and bubble together count once
    flush = 1'b1; in_f = rand_fields(); tick();
    check("fb_bubble3", 32'(bubble_cnt), 32'd3);
    flush = 1'b0; bubble_in = 1'b0;

    // Saturation
    freeze = 1'b1;
    for (int i = 0; i < 20; i++) begin in_f = rand_fields(); tick(); end
    check("sat_stall", 32'(stall_cnt), CNT_MAX);

    // Asynchronous reset mid-freeze
    #2 rst = 1'b1;
    #1 model_reset(); check_all();
    #1 rst = 1'b0; freeze = 1'b0;
    in_f = rand_fields(); tick();
    check("post_rst_valid", 32'(valid_out), 32'd1);

    // Random traffic, with mid-cycle input glitches
    for (int i = 0; i < 400; i++) begin
      freeze    = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 5) == 0);
      bubble_in = ($urandom_range(0, 4) == 0);
      in_f = rand_fields();
      #2 in_f = rand_fields();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
